// File: rtl/resp_window_checker.sv
// resp_window_checker: per-channel req/ack response-window checker.
// Each channel arms on req (with en) and expects ack within
// [MIN_DLY, MAX_DLY] cycles (MAX_DLY = 0: no upper bound). It emits one-cycle
// pass/fail pulses and keeps aggregate saturating statistics.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                arming enable for new triggers
//   clr               synchronous clear of counters and sticky flag
//   req[CH], ack[CH]  per-channel trigger / response
//   busy[CH]          channel has a pending attempt
//   pass[CH], fail[CH] one-cycle result pulses
//   pass_cnt, fail_cnt, ovl_cnt  saturating event counters (CNT_W bits)
//   err_sticky        latched failure flag
//
// Optional feature: define CHK_STICKY_ERR_EN to build the err_sticky flag
// register; otherwise err_sticky is tied low.
module resp_window_checker #(
    parameter int unsigned CH      = 4,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CH-1:0]    req,
    input  logic [CH-1:0]    ack,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    pass,
    output logic [CH-1:0]    fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] ovl_cnt,
    output logic             err_sticky
);

    localparam int unsigned K_TOP = (MAX_DLY > MIN_DLY) ? MAX_DLY : MIN_DLY;
    localparam int unsigned KW    = $clog2(K_TOP + 1);
    localparam int unsigned PC_W  = $clog2(CH + 1);
    localparam int unsigned SUM_W = CNT_W + PC_W;
    localparam bit          UNBOUNDED = (MAX_DLY == 0);

    localparam logic [KW-1:0]    K_MIN   = KW'(MIN_DLY);
    localparam logic [KW-1:0]    K_LAST  = KW'(MAX_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [KW-1:0] k_q     [CH];
    logic [KW-1:0] k_d     [CH];
    logic [CH-1:0] pass_d;
    logic [CH-1:0] fail_d;
    logic [CH-1:0] ovl_d;
    logic [CH-1:0] done;

    // Delay k lies inside the acceptance window.
    function automatic logic in_win(input logic [KW-1:0] k);
        return (k >= K_MIN) && (UNBOUNDED || (k <= K_LAST));
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [CH-1:0] v);
        logic [PC_W-1:0] p;
        p = '0;
        for (int i = 0; i < int'(CH); i++) begin
            p = p + PC_W'(v[i]);
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [PC_W-1:0]  p);
        logic [SUM_W-1:0] s;
        s = SUM_W'(c) + SUM_W'(p);
        if (s > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return CNT_W'(s);
    endfunction

    // Per-channel next-state, delay counter and event decode.
    always_comb begin
        pass_d = '0;
        fail_d = '0;
        ovl_d  = '0;
        done   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            state_d[i] = state_q[i];
            k_d[i]     = k_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (req[i] && en) begin
                        state_d[i] = S_WAIT;
                        k_d[i]     = KW'(1);
                    end
                end
                S_WAIT: begin
                    // ack in window wins over expiry at k == MAX_DLY.
                    if (ack[i] && in_win(k_q[i])) begin
                        pass_d[i] = 1'b1;
                        done[i]   = 1'b1;
                    end else if (!UNBOUNDED && (k_q[i] == K_LAST)) begin
                        fail_d[i] = 1'b1;
                        done[i]   = 1'b1;
                    end
                    if (done[i]) begin
                        // A trigger on the completing edge re-arms without overlap.
                        if (req[i] && en) begin
                            k_d[i] = KW'(1);
                        end else begin
                            state_d[i] = S_IDLE;
                            k_d[i]     = '0;
                        end
                    end else begin
                        ovl_d[i] = req[i];
                        // Unbounded mode parks k at MIN_DLY to keep it narrow.
                        if (!(UNBOUNDED && (k_q[i] >= K_MIN))) begin
                            k_d[i] = k_q[i] + KW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    k_d[i]     = '0;
                end
            endcase
        end
    end

    // Channel state and per-channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= S_IDLE;
                k_q[i]     <= '0;
            end
            busy <= '0;
            pass <= '0;
            fail <= '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                state_q[i] <= state_d[i];
                k_q[i]     <= k_d[i];
                busy[i]    <= (state_d[i] == S_WAIT);
            end
            pass <= pass_d;
            fail <= fail_d;
        end
    end

    // Aggregate counters; clr drops same-cycle events.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            ovl_cnt  <= '0;
        end else begin
            pass_cnt <= sat_add(pass_cnt, popcount(pass_d));
            fail_cnt <= sat_add(fail_cnt, popcount(fail_d));
            ovl_cnt  <= sat_add(ovl_cnt,  popcount(ovl_d));
        end
    end

`ifdef CHK_STICKY_ERR_EN
    logic err_q;

    // Latches the cycle after any fail pulse is visible.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_q <= 1'b0;
        end else if (|fail) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_resp_window_checker.sv
// Directed bench for resp_window_checker.
// Instance a: CH=4, MIN=1, MAX=8, CNT_W=3 (small counters to reach saturation).
// Instance b: CH=4, MIN=3, MAX=8.  Instance c: CH=1, MIN=1, MAX=0 (unbounded).
// All instances share stimulus; each scenario resets and checks one instance.
module tb_resp_window_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] ack = '0;

    logic [3:0] a_busy, a_pass, a_fail;
    logic [2:0] a_pass_cnt, a_fail_cnt, a_ovl_cnt;
    logic       a_err;
    logic [3:0] b_busy, b_pass, b_fail;
    logic [15:0] b_pass_cnt, b_fail_cnt, b_ovl_cnt;
    logic       b_err;
    logic       c_busy, c_pass, c_fail;
    logic [15:0] c_pass_cnt, c_fail_cnt, c_ovl_cnt;
    logic       c_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CHK_STICKY_ERR_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    resp_window_checker #(.CH(4), .MIN_DLY(1), .MAX_DLY(8), .CNT_W(3)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack),
        .busy(a_busy), .pass(a_pass), .fail(a_fail),
        .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt), .ovl_cnt(a_ovl_cnt),
        .err_sticky(a_err)
    );

    resp_window_checker #(.CH(4), .MIN_DLY(3), .MAX_DLY(8), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .ack(ack),
        .busy(b_busy), .pass(b_pass), .fail(b_fail),
        .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt), .ovl_cnt(b_ovl_cnt),
        .err_sticky(b_err)
    );

    resp_window_checker #(.CH(1), .MIN_DLY(1), .MAX_DLY(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req[0]), .ack(ack[0]),
        .busy(c_busy), .pass(c_pass), .fail(c_fail),
        .pass_cnt(c_pass_cnt), .fail_cnt(c_fail_cnt), .ovl_cnt(c_ovl_cnt),
        .err_sticky(c_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ack = '0;
        clr = 1'b0;
        en  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_busy",  32'(a_busy), 32'h0);
        check("rst_pass",  32'(a_pass), 32'h0);
        check("rst_fail",  32'(a_fail), 32'h0);
        check("rst_pcnt",  32'(a_pass_cnt), 32'h0);
        check("rst_fcnt",  32'(a_fail_cnt), 32'h0);
        check("rst_ocnt",  32'(a_ovl_cnt), 32'h0);
        check("rst_err",   32'(a_err), 32'h0);

        // en low blocks arming
        en = 1'b0; req = 4'b0001;
        tick();
        check("en0_busy", 32'(a_busy), 32'h0);

        // Pass at k=3; ack on the trigger edge ignored
        en = 1'b1; ack = 4'b0001;
        tick();                                   // T
        check("t1_busy", 32'(a_busy), 32'h1);
        check("t1_pass_trig", 32'(a_pass), 32'h0);
        req = '0; ack = '0;
        tick();                                   // T+1
        tick();                                   // T+2
        ack = 4'b0001;
        tick();                                   // T+3
        check("t1_pass", 32'(a_pass), 32'h1);
        check("t1_pcnt", 32'(a_pass_cnt), 32'h1);
        check("t1_busy_done", 32'(a_busy), 32'h0);
        ack = '0;
        tick();
        check("t1_pass_1cyc", 32'(a_pass), 32'h0);

        // Fail after MAX_DLY=8
        do_reset();
        req = 4'b0010;
        tick();                                   // T
        req = '0;
        repeat (7) tick();                        // T+7
        check("t2_busy_k7", 32'(a_busy), 32'h2);
        check("t2_nofail_k7", 32'(a_fail), 32'h0);
        tick();                                   // T+8
        check("t2_fail", 32'(a_fail), 32'h2);
        check("t2_fcnt", 32'(a_fail_cnt), 32'h1);
        check("t2_busy", 32'(a_busy), 32'h0);
        tick();
        check("t2_fail_1cyc", 32'(a_fail), 32'h0);
        check("t2_sticky", 32'(a_err), 32'(STICKY_EXP));

        // MIN_DLY=3: early ack ignored, pass at k=4
        do_reset();
        req = 4'b0100;
        tick();                                   // T
        req = '0; ack = 4'b0100;
        tick();                                   // T+1 (k=1)
        check("t3_early_pass", 32'(b_pass), 32'h0);
        check("t3_early_fail", 32'(b_fail), 32'h0);
        check("t3_early_busy", 32'(b_busy), 32'h4);
        ack = '0;
        tick();
        tick();
        ack = 4'b0100;
        tick();                                   // T+4 (k=4)
        check("t3_pass", 32'(b_pass), 32'h4);
        check("t3_pcnt", 32'(b_pass_cnt), 32'h1);
        ack = '0;

        // Overlap counting and re-arm on completing edge
        do_reset();
        req = 4'b0001;
        tick();                                   // T
        req = '0;
        tick();                                   // T+1
        req = 4'b0001;
        tick();                                   // T+2 overlap
        check("t4_ovl", 32'(a_ovl_cnt), 32'h1);
        check("t4_busy_ovl", 32'(a_busy), 32'h1);
        req = '0;
        tick();
        tick();                                   // T+4
        req = 4'b0001; ack = 4'b0001;
        tick();                                   // T+5 pass + re-arm
        check("t4_pass", 32'(a_pass), 32'h1);
        check("t4_rearm_busy", 32'(a_busy), 32'h1);
        check("t4_pcnt", 32'(a_pass_cnt), 32'h1);
        check("t4_ovl_hold", 32'(a_ovl_cnt), 32'h1);
        req = '0; ack = '0;
        tick();                                   // k=1, no ack
        ack = 4'b0001;
        tick();                                   // k=2
        check("t4_pass2", 32'(a_pass), 32'h1);
        check("t4_pcnt2", 32'(a_pass_cnt), 32'h2);
        check("t4_busy_end", 32'(a_busy), 32'h0);
        ack = '0;

        // Popcount, saturation (CNT_W=3 -> 7) and clr
        do_reset();
        req = 4'hF;
        tick();                                   // T
        ack = 4'hF;
        tick();                                   // T+1
        check("t5_pass_all", 32'(a_pass), 32'hF);
        check("t5_pcnt4", 32'(a_pass_cnt), 32'h4);
        tick();                                   // 4+4 saturates
        check("t5_pcnt_sat", 32'(a_pass_cnt), 32'h7);
        tick();
        check("t5_pcnt_hold", 32'(a_pass_cnt), 32'h7);
        req = '0; clr = 1'b1;
        tick();                                   // passes discarded by clr
        check("t5_clr_pcnt", 32'(a_pass_cnt), 32'h0);
        check("t5_clr_ocnt", 32'(a_ovl_cnt), 32'h0);
        check("t5_clr_busy", 32'(a_busy), 32'h0);
        clr = 1'b0; ack = '0;

        // Reset aborts a pending attempt at k=5
        do_reset();
        req = 4'b1000;
        tick();                                   // T
        req = '0;
        repeat (4) tick();                        // T+4
        rst = 1'b1; req = 4'b1000;
        tick();                                   // T+5 (k=5)
        check("t6_rst_busy", 32'(a_busy), 32'h0);
        check("t6_rst_pass", 32'(a_pass), 32'h0);
        check("t6_rst_fail", 32'(a_fail), 32'h0);
        rst = 1'b0; req = '0;
        repeat (10) tick();
        check("t6_after_busy", 32'(a_busy), 32'h0);
        check("t6_after_fcnt", 32'(a_fail_cnt), 32'h0);
        check("t6_after_pcnt", 32'(a_pass_cnt), 32'h0);

        // Unbounded window: ack at k=100 passes
        do_reset();
        req = 4'b0001;
        tick();                                   // T
        req = '0;
        repeat (99) tick();
        check("t7_busy", 32'(c_busy), 32'h1);
        check("t7_nofail", 32'(c_fail_cnt), 32'h0);
        ack = 4'b0001;
        tick();                                   // T+100
        check("t7_pass", 32'(c_pass), 32'h1);
        check("t7_pcnt", 32'(c_pass_cnt), 32'h1);
        check("t7_busy_end", 32'(c_busy), 32'h0);
        ack = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
